// File: rtl/winograd_tile_streamer_if.sv
// Tile stream bundle between the Winograd tile streamer and its consumer.
// The master presents one TILE x TILE window per handshake together with its grid position.
`timescale 1ns/1ps
interface winograd_tile_streamer_if #(
  parameter int DATA_W = 32,
  parameter int TILE   = 6,
  parameter int IDX_W  = 2
);
  logic              tile_valid;
  logic              tile_ready;
  logic [DATA_W-1:0] tile_data [TILE][TILE];
  logic [IDX_W-1:0]  tile_row;
  logic [IDX_W-1:0]  tile_col;
  logic              tile_last;

  modport master (
    output tile_valid, tile_data, tile_row, tile_col, tile_last,
    input  tile_ready
  );

  modport slave (
    input  tile_valid, tile_data, tile_row, tile_col, tile_last,
    output tile_ready
  );
endinterface

// File: rtl/winograd_tile_streamer.sv
// Captures an image on start and streams overlapping, zero-padded TILE x TILE windows
// in raster order at STRIDE steps, one tile per accepted handshake.
`timescale 1ns/1ps
module winograd_tile_streamer #(
  parameter int DATA_W   = 32,
  parameter int IMG_ROWS = 10,
  parameter int IMG_COLS = 12,
  parameter int TILE     = 6,
  parameter int STRIDE   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_W-1:0]     image [IMG_ROWS][IMG_COLS],
  winograd_tile_streamer_if.master tile_if,
  output logic                  busy,
  output logic                  done
);
  localparam int T_ROWS = (IMG_ROWS + STRIDE - 1) / STRIDE;
  localparam int T_COLS = (IMG_COLS + STRIDE - 1) / STRIDE;
  localparam int T_MAX  = (T_ROWS > T_COLS) ? T_ROWS : T_COLS;
  localparam int IDX_W  = (T_MAX > 1) ? $clog2(T_MAX) : 1;
  localparam int RW     = (IMG_ROWS > 1) ? $clog2(IMG_ROWS) : 1;
  localparam int CW     = (IMG_COLS > 1) ? $clog2(IMG_COLS) : 1;

  localparam logic [IDX_W-1:0] ROW_END = IDX_W'(T_ROWS - 1);
  localparam logic [IDX_W-1:0] COL_END = IDX_W'(T_COLS - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STREAM = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  logic [1:0]        state;
  logic [DATA_W-1:0] img_buf  [IMG_ROWS][IMG_COLS];
  logic [DATA_W-1:0] nxt_tile [TILE][TILE];
  logic [IDX_W-1:0]  nxt_row;
  logic [IDX_W-1:0]  nxt_col;
  logic              nxt_last;
  logic              accept;
  logic              hs;
  logic              load;

  assign accept = (state == IDLE) && start;
  assign hs     = (state == STREAM) && tile_if.tile_ready;
  assign load   = accept || (hs && !tile_if.tile_last);

  assign tile_if.tile_valid = (state == STREAM);
  assign busy               = (state != IDLE);
  assign done               = (state == FINISH);

  // Position of the tile to present after the next load: origin on capture, else raster successor.
  always_comb begin
    nxt_row = tile_if.tile_row;
    nxt_col = tile_if.tile_col + 1'b1;
    if (state == IDLE) begin
      nxt_row = '0;
      nxt_col = '0;
    end else if (tile_if.tile_col == COL_END) begin
      nxt_row = tile_if.tile_row + 1'b1;
      nxt_col = '0;
    end
  end

  assign nxt_last = (nxt_row == ROW_END) && (nxt_col == COL_END);

  // The first tile is cut straight from the input image because the buffer loads on the same edge.
  always_comb begin
    int r;
    int c;
    r = 0;
    c = 0;
    for (int i = 0; i < TILE; i++) begin
      for (int j = 0; j < TILE; j++) begin
        r = int'(nxt_row) * STRIDE + i;
        c = int'(nxt_col) * STRIDE + j;
        nxt_tile[i][j] = '0;
        if (r < IMG_ROWS && c < IMG_COLS)
          nxt_tile[i][j] = (state == IDLE) ? image[RW'(r)][CW'(c)] : img_buf[RW'(r)][CW'(c)];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int r = 0; r < IMG_ROWS; r++)
        for (int c = 0; c < IMG_COLS; c++)
          img_buf[r][c] <= image[r][c];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      tile_if.tile_row  <= '0;
      tile_if.tile_col  <= '0;
      tile_if.tile_last <= 1'b0;
      for (int i = 0; i < TILE; i++)
        for (int j = 0; j < TILE; j++)
          tile_if.tile_data[i][j] <= '0;
    end else begin
      if (load) begin
        tile_if.tile_row  <= nxt_row;
        tile_if.tile_col  <= nxt_col;
        tile_if.tile_last <= nxt_last;
        for (int i = 0; i < TILE; i++)
          for (int j = 0; j < TILE; j++)
            tile_if.tile_data[i][j] <= nxt_tile[i][j];
      end
      case (state)
        IDLE:    if (start) state <= STREAM;
        STREAM:  if (tile_if.tile_ready && tile_if.tile_last) state <= FINISH;
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_winograd_tile_streamer.sv
// Randomized bench for winograd_tile_streamer: three image geometries checked against a
// window-extraction model computed directly from image coordinates.
`timescale 1ns/1ps
module tb_winograd_tile_streamer;
  logic clk;
  logic rst;
  logic start0, start1, start2;
  logic busy0, busy1, busy2;
  logic done0, done1, done2;
  logic trash;

  logic [31:0] mimg [16][16];
  logic [31:0] img0 [10][12];
  logic [31:0] img1 [8][8];
  logic [31:0] img2 [1][1];

  winograd_tile_streamer_if #(.DATA_W(32), .TILE(6), .IDX_W(2)) if0 ();
  winograd_tile_streamer_if #(.DATA_W(32), .TILE(6), .IDX_W(1)) if1 ();
  winograd_tile_streamer_if #(.DATA_W(32), .TILE(6), .IDX_W(1)) if2 ();

  winograd_tile_streamer #(.DATA_W(32), .IMG_ROWS(10), .IMG_COLS(12), .TILE(6), .STRIDE(4)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .image(img0), .tile_if(if0.master), .busy(busy0), .done(done0));
  winograd_tile_streamer #(.DATA_W(32), .IMG_ROWS(8), .IMG_COLS(8), .TILE(6), .STRIDE(4)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .image(img1), .tile_if(if1.master), .busy(busy1), .done(done1));
  winograd_tile_streamer #(.DATA_W(32), .IMG_ROWS(1), .IMG_COLS(1), .TILE(6), .STRIDE(4)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .image(img2), .tile_if(if2.master), .busy(busy2), .done(done2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 12; c++)
        img0[r][c] = trash ? 32'hFFFF_FFFF : mimg[r][c];
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        img1[r][c] = trash ? 32'hFFFF_FFFF : mimg[r][c];
    img2[0][0] = trash ? 32'hFFFF_FFFF : mimg[0][0];
  end

  int n_vec;
  int n_err;

  logic        o_valid, o_last, o_busy, o_done;
  int          o_row, o_col;
  logic [31:0] got [6][6];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Window element at (i,j) of grid tile (tr,tc): image pixel if inside, zero padding otherwise.
  function automatic logic [31:0] exp_el(input int rows, input int cols, input int tr, input int tc,
                                         input int i, input int j);
    int r, c;
    r = tr * 4 + i;
    c = tc * 4 + j;
    if (r < rows && c < cols) return mimg[r][c];
    return 32'd0;
  endfunction

  task automatic sample(input int w);
    case (w)
      0: begin
        o_valid = if0.tile_valid; o_last = if0.tile_last; o_busy = busy0; o_done = done0;
        o_row = int'(if0.tile_row); o_col = int'(if0.tile_col);
        for (int i = 0; i < 6; i++) for (int j = 0; j < 6; j++) got[i][j] = if0.tile_data[i][j];
      end
      1: begin
        o_valid = if1.tile_valid; o_last = if1.tile_last; o_busy = busy1; o_done = done1;
        o_row = int'(if1.tile_row); o_col = int'(if1.tile_col);
        for (int i = 0; i < 6; i++) for (int j = 0; j < 6; j++) got[i][j] = if1.tile_data[i][j];
      end
      default: begin
        o_valid = if2.tile_valid; o_last = if2.tile_last; o_busy = busy2; o_done = done2;
        o_row = int'(if2.tile_row); o_col = int'(if2.tile_col);
        for (int i = 0; i < 6; i++) for (int j = 0; j < 6; j++) got[i][j] = if2.tile_data[i][j];
      end
    endcase
  endtask

  task automatic drive(input int w, input logic s, input logic r);
    case (w)
      0:       begin start0 = s; if0.tile_ready = r; end
      1:       begin start1 = s; if1.tile_ready = r; end
      default: begin start2 = s; if2.tile_ready = r; end
    endcase
  endtask

  task automatic chk_zero(input int w);
    sample(w);
    chk("rst_valid", o_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_last", o_last, 0);
    chk("rst_row", o_row, 0);
    chk("rst_col", o_col, 0);
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++)
        chk("rst_data", got[i][j], 0);
  endtask

  task automatic fill_random();
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        mimg[r][c] = $urandom;
  endtask

  // Called at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle again.
  task automatic run_stream(input int w, input int rows, input int cols, input int pct,
                            input bit hold, input bit trash_img, input int abort_at, input int dir);
    int tr_n, tc_n, total, idx, cyc, er, ec;
    bit rdy;
    tr_n  = (rows + 3) / 4;
    tc_n  = (cols + 3) / 4;
    total = tr_n * tc_n;
    idx   = 0;
    cyc   = 0;
    sample(w);
    chk("idle_busy", o_busy, 0);
    chk("idle_valid", o_valid, 0);
    drive(w, 1'b1, 1'b0);
    @(posedge clk); #1;
    drive(w, hold, 1'b0);
    if (trash_img) trash = 1'b1;
    while (idx < total && cyc < 400) begin
      er = idx / tc_n;
      ec = idx % tc_n;
      sample(w);
      chk("valid", o_valid, 1);
      chk("busy", o_busy, 1);
      chk("done_early", o_done, 0);
      chk("row", o_row, er);
      chk("col", o_col, ec);
      chk("last", o_last, (idx == total - 1));
      for (int i = 0; i < 6; i++)
        for (int j = 0; j < 6; j++)
          chk("data", got[i][j], exp_el(rows, cols, er, ec, i, j));
      if (dir == 1 && er == 0 && ec == 2) begin
        chk("t02_13", got[1][3], 32'h1B);
        chk("t02_14", got[1][4], 32'h0);
      end
      if (dir == 1 && er == 2 && ec == 0)
        for (int i = 2; i < 6; i++)
          for (int j = 0; j < 6; j++)
            chk("t20_pad", got[i][j], 32'h0);
      if (dir == 2 && er == 1 && ec == 1) begin
        chk("t11_33", got[3][3], mimg[7][7]);
        chk("t11_40", got[4][0], 32'h0);
      end
      rdy = ($urandom_range(99) < pct);
      drive(w, hold, rdy);
      if (rdy) idx++;
      @(posedge clk); #1;
      cyc++;
      if (abort_at >= 0 && idx == abort_at) begin
        rst = 1'b1;
        #1;
        chk_zero(w);
        drive(w, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk_zero(w);
        return;
      end
    end
    chk("hs_count", idx, total);
    drive(w, hold, 1'b0);
    sample(w);
    chk("fin_valid", o_valid, 0);
    chk("fin_done", o_done, 1);
    chk("fin_busy", o_busy, 1);
    @(posedge clk); #1;
    drive(w, 1'b0, 1'b0);
    trash = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sample(w);
      chk("post_done", o_done, 0);
      chk("post_busy", o_busy, 0);
      chk("post_valid", o_valid, 0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    trash = 1'b0;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    if0.tile_ready = 1'b0; if1.tile_ready = 1'b0; if2.tile_ready = 1'b0;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        mimg[r][c] = r * 16 + c;
    repeat (3) @(posedge clk);
    #1;
    chk_zero(0);
    chk_zero(1);
    chk_zero(2);
    rst = 1'b0;
    @(posedge clk); #1;

    run_stream(0, 10, 12, 100, 1'b0, 1'b0, -1, 1);
    fill_random();
    run_stream(0, 10, 12, 50, 1'b0, 1'b1, -1, 0);
    fill_random();
    run_stream(0, 10, 12, 100, 1'b1, 1'b0, -1, 0);
    fill_random();
    run_stream(0, 10, 12, 70, 1'b0, 1'b0, 4, 0);
    run_stream(0, 10, 12, 100, 1'b0, 1'b0, -1, 0);
    fill_random();
    run_stream(1, 8, 8, 100, 1'b0, 1'b0, -1, 2);
    fill_random();
    run_stream(1, 8, 8, 40, 1'b1, 1'b1, -1, 2);
    fill_random();
    run_stream(2, 1, 1, 60, 1'b0, 1'b0, -1, 0);
    fill_random();
    run_stream(2, 1, 1, 100, 1'b1, 1'b1, -1, 0);
    for (int k = 0; k < 3; k++) begin
      fill_random();
      run_stream(0, 10, 12, $urandom_range(90, 20), 1'(k & 1), 1'b1, -1, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
